// File: rtl/rf_wr_arbiter_pkg.sv
// Shared register-file write bus format and LLU result entry layout.
// The WB stage, the forwarding path and the write-port arbiter all use this package.
package rf_wr_arbiter_pkg;

  localparam int XLEN      = 64;
  localparam int REG_AW    = 5;
  localparam int NUM_REGS  = 32;
  localparam int RF_BUS_WD = 1 + REG_AW + XLEN;

  // Bus layout: {we, waddr[4:0], wdata[XLEN-1:0]}
  localparam int WE_BIT    = RF_BUS_WD - 1;
  localparam int WADDR_LSB = XLEN;
  localparam int WDATA_LSB = 0;

  localparam logic [REG_AW-1:0] X0 = '0;

  typedef struct packed {
    logic              we;
    logic [REG_AW-1:0] waddr;
    logic [XLEN-1:0]   wdata;
  } rf_bus_t;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } llu_entry_t;

  localparam int LLU_ENTRY_WD = REG_AW + XLEN;

  function automatic logic [RF_BUS_WD-1:0] pack_bus(input logic we,
                                                    input logic [REG_AW-1:0] waddr,
                                                    input logic [XLEN-1:0] wdata);
    logic [RF_BUS_WD-1:0] b;
    b = '0;
    b[WE_BIT] = we;
    b[WADDR_LSB +: REG_AW] = waddr;
    b[WDATA_LSB +: XLEN] = wdata;
    return b;
  endfunction

endpackage

// File: rtl/rf_wr_fifo.sv
// Synchronous FIFO holding LLU results until they win the RF write port.
// Flags are registered; pointers wrap naturally because DEPTH is a power of two.
module rf_wr_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 69,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [CW-1:0]    count_nxt;

  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign count_nxt = count + CW'(do_push) - CW'(do_pop);
  assign rdata     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  // Storage carries no reset; entries are only visible through the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/rf_wr_arbiter.sv
// Arbitrates the single RF write port between in-order WB and buffered LLU results,
// tracks pending LLU destinations, and requests a stall when LLU results starve.
module rf_wr_arbiter
  import rf_wr_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int AGE_MAX    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [RF_BUS_WD-1:0] wb_bus,
  input  logic                 llu_valid,
  input  logic [REG_AW-1:0]    llu_rd,
  input  logic [XLEN-1:0]      llu_data,
  output logic                 llu_ready,
  input  logic                 issue_valid,
  input  logic [REG_AW-1:0]    issue_rd,
  output logic [RF_BUS_WD-1:0] rf_bus,
  output logic [NUM_REGS-1:0]  rd_busy,
  output logic                 stall_req,
  output logic                 err_waw
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int AW = $clog2(AGE_MAX + 1);

  logic                    wb_we;
  logic [REG_AW-1:0]       wb_waddr;
  logic                    wb_wins;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [CW-1:0]           fifo_count;
  logic [LLU_ENTRY_WD-1:0] head_raw;
  llu_entry_t              head;
  llu_entry_t              push_entry;
  logic                    push;
  logic                    pop;
  logic [NUM_REGS-1:0]     busy_nxt;
  logic                    err_hit;
  logic [AW-1:0]           age;
  logic [AW-1:0]           age_nxt;
  logic                    stall_nxt;

  assign wb_we    = wb_bus[WE_BIT];
  assign wb_waddr = wb_bus[WADDR_LSB +: REG_AW];
  // A WB write to x0 is not a write, so it leaves the port to the FIFO head.
  assign wb_wins  = wb_we && (wb_waddr != X0);

  assign llu_ready       = !fifo_full;
  assign push            = llu_valid && !fifo_full && (llu_rd != X0);
  assign pop             = !fifo_empty && !wb_wins;
  assign push_entry.rd   = llu_rd;
  assign push_entry.data = llu_data;
  assign head            = head_raw;

  rf_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (LLU_ENTRY_WD)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head_raw),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    rf_bus = '0;
    if (wb_wins)          rf_bus = wb_bus;
    else if (!fifo_empty) rf_bus = pack_bus(1'b1, head.rd, head.data);
  end

  // Clear for the retiring head first so a same-edge issue to that register wins.
  always_comb begin
    busy_nxt = rd_busy;
    if (pop) busy_nxt[head.rd] = 1'b0;
    if (issue_valid) busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  assign err_hit = (issue_valid && rd_busy[issue_rd]) || (wb_we && rd_busy[wb_waddr]);

  always_comb begin
    age_nxt = age;
    if (pop || fifo_empty)        age_nxt = '0;
    else if (age < AW'(AGE_MAX))  age_nxt = age + AW'(1);
  end

  assign stall_nxt = (fifo_count == CW'(FIFO_DEPTH)) ||
                     ((age >= AW'(AGE_MAX - 1)) && !fifo_empty && !pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_busy   <= '0;
      age       <= '0;
      stall_req <= 1'b0;
      err_waw   <= 1'b0;
    end else begin
      rd_busy   <= busy_nxt;
      age       <= age_nxt;
      stall_req <= stall_nxt;
      if (err_hit) err_waw <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Bench for rf_wr_arbiter: directed vector table, corner-case sequences and
// randomized traffic, all checked against a queue-based model of the write-port rules.
module tb_rf_wr_arbiter;
  import rf_wr_arbiter_pkg::*;

  localparam int DEPTH   = 2;
  localparam int AGE_MAX = 8;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [RF_BUS_WD-1:0] wb_bus = '0;
  logic                 llu_valid = 1'b0;
  logic [4:0]           llu_rd = '0;
  logic [63:0]          llu_data = '0;
  logic                 llu_ready;
  logic                 issue_valid = 1'b0;
  logic [4:0]           issue_rd = '0;
  logic [RF_BUS_WD-1:0] rf_bus;
  logic [31:0]          rd_busy;
  logic                 stall_req;
  logic                 err_waw;

  int checks = 0;
  int failures = 0;

  rf_wr_arbiter #(.FIFO_DEPTH(DEPTH), .AGE_MAX(AGE_MAX)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wb_bus      (wb_bus),
    .llu_valid   (llu_valid),
    .llu_rd      (llu_rd),
    .llu_data    (llu_data),
    .llu_ready   (llu_ready),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .rf_bus      (rf_bus),
    .rd_busy     (rd_busy),
    .stall_req   (stall_req),
    .err_waw     (err_waw)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  typedef struct {
    bit          w_we;
    logic [4:0]  w_a;
    logic [63:0] w_d;
    bit          l_v;
    logic [4:0]  l_rd;
    logic [63:0] l_d;
    bit          i_v;
    logic [4:0]  i_rd;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic [69:0] e_rf;
    bit          e_rdy;
    bit          e_stall;
    logic [31:0] e_busy;
  } vec_t;

  // ---------------- reference model ----------------
  logic [68:0] exp_q[$];   // pending LLU results {rd, data}, oldest first
  bit [31:0]   m_busy;
  int          m_age;
  bit          m_stall;
  bit          m_err;

  // mid-cycle samples of the DUT from the last step
  logic [69:0] s_rf;
  logic [31:0] s_busy;
  logic        s_rdy, s_stall, s_err;

  function automatic stim_t mk(bit w_we, logic [4:0] w_a, logic [63:0] w_d, bit l_v,
                               logic [4:0] l_rd, logic [63:0] l_d, bit i_v, logic [4:0] i_rd);
    stim_t s;
    s.w_we = w_we; s.w_a = w_a; s.w_d = w_d;
    s.l_v = l_v; s.l_rd = l_rd; s.l_d = l_d;
    s.i_v = i_v; s.i_rd = i_rd;
    return s;
  endfunction

  task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_busy = '0;
    m_age = 0;
    m_stall = 1'b0;
    m_err = 1'b0;
  endtask

  // ---------------- driver ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    wb_bus = '0; llu_valid = 1'b0; llu_rd = '0; llu_data = '0;
    issue_valid = 1'b0; issue_rd = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  // One clock: drive, compare mid-cycle against the model, then advance the model.
  task automatic step(input stim_t s);
    logic [69:0] e_rf;
    bit          e_rdy, wb_wins, popped;
    int          size_before;
    logic [68:0] h;
    wb_bus = {s.w_we, s.w_a, s.w_d};
    llu_valid = s.l_v; llu_rd = s.l_rd; llu_data = s.l_d;
    issue_valid = s.i_v; issue_rd = s.i_rd;
    #3;
    wb_wins = s.w_we && (s.w_a != 5'd0);
    if (wb_wins)               e_rf = {1'b1, s.w_a, s.w_d};
    else if (exp_q.size() > 0) e_rf = {1'b1, exp_q[0]};
    else                       e_rf = '0;
    e_rdy = (exp_q.size() < DEPTH);
    s_rf = rf_bus; s_busy = rd_busy; s_rdy = llu_ready; s_stall = stall_req; s_err = err_waw;
    check("rf_bus", s_rf, e_rf);
    check("llu_ready", 70'(s_rdy), 70'(e_rdy));
    check("rd_busy", 70'(s_busy), 70'(m_busy));
    check("stall_req", 70'(s_stall), 70'(m_stall));
    check("err_waw", 70'(s_err), 70'(m_err));
    @(posedge clk);
    size_before = exp_q.size();
    popped = !wb_wins && (size_before > 0);
    if ((s.i_v && m_busy[s.i_rd]) || (s.w_we && m_busy[s.w_a])) m_err = 1'b1;
    m_stall = (size_before == DEPTH) || (m_age >= AGE_MAX - 1 && size_before > 0 && !popped);
    if (popped || size_before == 0) m_age = 0;
    else if (m_age < AGE_MAX)       m_age++;
    if (popped) begin
      h = exp_q.pop_front();
      m_busy[h[68:64]] = 1'b0;
    end
    if (s.i_v && s.i_rd != 5'd0) m_busy[s.i_rd] = 1'b1;
    if (s.l_v && e_rdy && s.l_rd != 5'd0) exp_q.push_back({s.l_rd, s.l_d});
    #1;
  endtask

  // ---------------- stimulus ----------------
  vec_t  vecs[$];
  stim_t idle;
  stim_t wb7;

  task automatic add_vec(input stim_t s, input logic [69:0] erf, input bit erdy,
                         input bit estall, input logic [31:0] ebusy);
    vec_t v;
    v.s = s; v.e_rf = erf; v.e_rdy = erdy; v.e_stall = estall; v.e_busy = ebusy;
    vecs.push_back(v);
  endtask

  initial begin
    int rise_k;
    stim_t r;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0);
    wb7  = mk(1, 7, 64'h1, 0, 0, 0, 0, 0);

    // LLU-only write, then WB/LLU collision; expectations are pre-edge values
    add_vec(mk(0, 0, 0, 0, 0, 0, 1, 5),          '0,                      1, 0, 32'h0);
    add_vec(idle,                                 '0,                      1, 0, 32'h20);
    add_vec(idle,                                 '0,                      1, 0, 32'h20);
    add_vec(mk(0, 0, 0, 1, 5, 64'hDEAD, 0, 0),   '0,                      1, 0, 32'h20);
    add_vec(idle,                                 {1'b1, 5'd5, 64'hDEAD},  1, 0, 32'h20);
    add_vec(idle,                                 '0,                      1, 0, 32'h0);
    add_vec(mk(0, 0, 0, 0, 0, 0, 1, 9),          '0,                      1, 0, 32'h0);
    add_vec(mk(1, 7, 64'h1, 1, 9, 64'h42, 0, 0), {1'b1, 5'd7, 64'h1},     1, 0, 32'h200);
    add_vec(wb7,                                  {1'b1, 5'd7, 64'h1},     1, 0, 32'h200);
    add_vec(wb7,                                  {1'b1, 5'd7, 64'h1},     1, 0, 32'h200);
    add_vec(wb7,                                  {1'b1, 5'd7, 64'h1},     1, 0, 32'h200);
    add_vec(idle,                                 {1'b1, 5'd9, 64'h42},    1, 0, 32'h200);
    add_vec(idle,                                 '0,                      1, 0, 32'h0);

    do_reset();
    step(idle);
    check("reset_rf_bus", s_rf, '0);
    check("reset_rd_busy", 70'(s_busy), '0);
    check("reset_llu_ready", 70'(s_rdy), 70'(1));
    check("reset_stall_req", 70'(s_stall), '0);
    check("reset_err_waw", 70'(s_err), '0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].s);
      check($sformatf("vec%0d_rf_bus", i), s_rf, vecs[i].e_rf);
      check($sformatf("vec%0d_llu_ready", i), 70'(s_rdy), 70'(vecs[i].e_rdy));
      check($sformatf("vec%0d_stall_req", i), 70'(s_stall), 70'(vecs[i].e_stall));
      check($sformatf("vec%0d_rd_busy", i), 70'(s_busy), 70'(vecs[i].e_busy));
    end

    // FIFO full under continuous WB, then drain with WB bubbled
    do_reset();
    step(mk(0, 0, 0, 0, 0, 0, 1, 3));
    step(mk(0, 0, 0, 0, 0, 0, 1, 4));
    step(mk(1, 7, 64'h1, 1, 3, 64'h33, 0, 0));
    step(mk(1, 7, 64'h1, 1, 4, 64'h44, 0, 0));
    step(wb7);
    check("full_llu_ready", 70'(s_rdy), '0);
    check("full_stall_not_yet", 70'(s_stall), '0);
    step(idle);
    check("full_stall_set", 70'(s_stall), 70'(1));
    check("full_pop_x3", s_rf, {1'b1, 5'd3, 64'h33});
    step(idle);
    check("full_pop_x4", s_rf, {1'b1, 5'd4, 64'h44});
    step(idle);
    check("full_stall_clear", 70'(s_stall), '0);
    check("full_busy_clear", 70'(s_busy), '0);

    // Aging: one entry starved by continuous WB writes
    do_reset();
    step(mk(0, 0, 0, 0, 0, 0, 1, 11));
    step(mk(1, 7, 64'h1, 1, 11, 64'hBB, 0, 0));
    rise_k = 0;
    for (int k = 1; k <= 10; k++) begin
      step(wb7);
      if (s_stall && rise_k == 0) rise_k = k;
    end
    check("age_stall_rise_cycle", 70'(rise_k), 70'(AGE_MAX + 1));
    step(idle);
    check("age_commit", s_rf, {1'b1, 5'd11, 64'hBB});
    step(idle);
    check("age_stall_clear", 70'(s_stall), '0);

    // x0 handling and protocol errors
    do_reset();
    step(mk(0, 0, 0, 0, 0, 0, 1, 12));
    step(mk(0, 0, 0, 1, 12, 64'h1212, 0, 0));
    step(mk(1, 0, 64'h55, 0, 0, 0, 0, 0));
    check("wb_x0_yields", s_rf, {1'b1, 5'd12, 64'h1212});
    step(mk(0, 0, 0, 1, 0, 64'h99, 0, 0));
    step(idle);
    check("llu_x0_dropped", s_rf, '0);
    step(mk(0, 0, 0, 0, 0, 0, 1, 5));
    step(mk(0, 0, 0, 0, 0, 0, 1, 5));
    check("err_before_edge", 70'(s_err), '0);
    step(idle);
    check("err_set", 70'(s_err), 70'(1));
    step(mk(0, 0, 0, 1, 5, 64'h5, 0, 0));
    step(mk(0, 0, 0, 0, 0, 0, 1, 5));
    check("pop_x5_same_issue", s_rf, {1'b1, 5'd5, 64'h5});
    step(idle);
    check("set_wins_busy5", 70'(s_busy), 70'(32'h20));
    check("err_sticky", 70'(s_err), 70'(1));

    // Randomized traffic; WB honours stall_req, with a reset mid-run
    for (int seg = 0; seg < 2; seg++) begin
      do_reset();
      for (int n = 0; n < 300; n++) begin
        r.w_we = ($urandom_range(0, 99) < 60) && !s_stall;
        r.w_a  = 5'($urandom_range(0, 31));
        r.w_d  = {$urandom, $urandom};
        r.l_v  = ($urandom_range(0, 99) < 35);
        r.l_rd = 5'($urandom_range(0, 31));
        r.l_d  = {$urandom, $urandom};
        r.i_v  = ($urandom_range(0, 99) < 30);
        r.i_rd = 5'($urandom_range(0, 31));
        step(r);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
